smi_request_frame_router: RTL and testbench

//   Sits directly upstream of smiAxiWriteAdaptor and its read-side twin. Accepts one SMI

---
 rtl/smi_request_frame_router.sv | 163 ++++++++++++++++
 tb/tb_smi_request_frame_router.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_request_frame_router.sv
// SMI request frame router: decodes the head flit type and steers whole frames to write/read outputs, discarding unknown types.
// Latency 1 cycle through a 2-entry output FIFO. Input stop is the registered full flag of the current destination.

module smi_req_fifo2 #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [Width-1:0] pushDat,
  input  logic             pop,
  output logic [Width-1:0] headDat,
  output logic             notEmpty,
  output logic             full
);

  logic [Width-1:0] mem [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushDat;
  end

  assign headDat  = mem[rdPtr];
  assign notEmpty = (count != 2'd0);
  assign full     = (count == 2'd2);

endmodule

module smi_request_frame_router #(
  parameter int         DataIndexSize = 4,
  parameter logic [7:0] WriteReqId    = 8'h02,
  parameter logic [7:0] ReadReqId     = 8'h01,
  localparam int        DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiWrReqReady,
  output logic [7:0]           smiWrReqEofc,
  output logic [DataWidth-1:0] smiWrReqData,
  input  logic                 smiWrReqStop,
  output logic                 smiRdReqReady,
  output logic [7:0]           smiRdReqEofc,
  output logic [DataWidth-1:0] smiRdReqData,
  input  logic                 smiRdReqStop,
  output logic [7:0]           dropCount
);

  localparam logic [1:0] StHead  = 2'd0;
  localparam logic [1:0] StFwdWr = 2'd1;
  localparam logic [1:0] StFwdRd = 2'd2;
  localparam logic [1:0] StDrop  = 2'd3;
  localparam int         EntryW  = DataWidth + 8;

  logic [1:0]        state;
  logic [1:0]        headDest;
  logic [1:0]        curDest;
  logic              inXfer;
  logic              wrPush;
  logic              rdPush;
  logic              wrPop;
  logic              rdPop;
  logic              wrFull;
  logic              rdFull;
  logic [EntryW-1:0] wrHead;
  logic [EntryW-1:0] rdHead;

  // Destination states double as the destination code, so a head decode maps straight onto the next state.
  always_comb begin
    headDest = StDrop;
    if (smiReqData[7:0] == WriteReqId)     headDest = StFwdWr;
    else if (smiReqData[7:0] == ReadReqId) headDest = StFwdRd;
    curDest = (state == StHead) ? headDest : state;
  end

  always_comb begin
    smiReqStop = 1'b0;
    if (!nreset) begin
      smiReqStop = 1'b1;
    end else if ((state == StHead) && !smiReqReady) begin
      smiReqStop = 1'b1;
    end else begin
      case (curDest)
        StFwdWr: smiReqStop = wrFull;
        StFwdRd: smiReqStop = rdFull;
        default: smiReqStop = 1'b0;
      endcase
    end
  end

  assign inXfer = smiReqReady & ~smiReqStop;
  assign wrPush = inXfer & (curDest == StFwdWr);
  assign rdPush = inXfer & (curDest == StFwdRd);
  assign wrPop  = smiWrReqReady & ~smiWrReqStop;
  assign rdPop  = smiRdReqReady & ~smiRdReqStop;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= StHead;
    end else if (inXfer) begin
      state <= (smiReqEofc != 8'd0) ? StHead : curDest;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dropCount <= 8'd0;
    end else if (inXfer && (state == StHead) && (headDest == StDrop) && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end

  smi_req_fifo2 #(.Width(EntryW)) wrFifo (
    .clk      (clk),
    .nreset   (nreset),
    .push     (wrPush),
    .pushDat  ({smiReqEofc, smiReqData}),
    .pop      (wrPop),
    .headDat  (wrHead),
    .notEmpty (smiWrReqReady),
    .full     (wrFull)
  );

  smi_req_fifo2 #(.Width(EntryW)) rdFifo (
    .clk      (clk),
    .nreset   (nreset),
    .push     (rdPush),
    .pushDat  ({smiReqEofc, smiReqData}),
    .pop      (rdPop),
    .headDat  (rdHead),
    .notEmpty (smiRdReqReady),
    .full     (rdFull)
  );

  assign smiWrReqEofc = wrHead[EntryW-1:DataWidth];
  assign smiWrReqData = wrHead[DataWidth-1:0];
  assign smiRdReqEofc = rdHead[EntryW-1:DataWidth];
  assign smiRdReqData = rdHead[DataWidth-1:0];

endmodule

// File: tb/tb_smi_request_frame_router.sv
// Randomized bench for smi_request_frame_router: queue-based frame model checked every cycle, plus directed scenarios.
module tb_smi_request_frame_router;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          nreset;
  logic          smiReqReady;
  logic [7:0]    smiReqEofc;
  logic [DW-1:0] smiReqData;
  logic          smiReqStop;
  logic          smiWrReqReady;
  logic [7:0]    smiWrReqEofc;
  logic [DW-1:0] smiWrReqData;
  logic          smiWrReqStop;
  logic          smiRdReqReady;
  logic [7:0]    smiRdReqEofc;
  logic [DW-1:0] smiRdReqData;
  logic          smiRdReqStop;
  logic [7:0]    dropCount;

  smi_request_frame_router #(.DataIndexSize(4), .WriteReqId(8'h02), .ReadReqId(8'h01)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .smiReqReady   (smiReqReady),
    .smiReqEofc    (smiReqEofc),
    .smiReqData    (smiReqData),
    .smiReqStop    (smiReqStop),
    .smiWrReqReady (smiWrReqReady),
    .smiWrReqEofc  (smiWrReqEofc),
    .smiWrReqData  (smiWrReqData),
    .smiWrReqStop  (smiWrReqStop),
    .smiRdReqReady (smiRdReqReady),
    .smiRdReqEofc  (smiRdReqEofc),
    .smiRdReqData  (smiRdReqData),
    .smiRdReqStop  (smiRdReqStop),
    .dropCount     (dropCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one queue of {eofc,data} per output, plus where the current frame is going (0 = next flit is a head).
  logic [DW+7:0] wrQ[$];
  logic [DW+7:0] rdQ[$];
  int            mFrame = 0;
  logic [7:0]    expDrop = 8'd0;
  int            wrHold = 0;
  int            rdHold = 0;
  bit            randStops = 1'b0;
  bit            sawStop = 1'b0;
  logic [DW-1:0] headData;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] t);
    if (t == 8'h02) return 1;
    if (t == 8'h01) return 2;
    return 3;
  endfunction

  task automatic applyStops();
    smiWrReqStop = (wrHold > 0) || (randStops && ($urandom_range(0, 3) == 0));
    smiRdReqStop = (rdHold > 0) || (randStops && ($urandom_range(0, 3) == 0));
    if (wrHold > 0) wrHold--;
    if (rdHold > 0) rdHold--;
  endtask

  task automatic setHold(input int w, input int r);
    wrHold = w;
    rdHold = r;
    applyStops();
  endtask

  // One cycle: compare DUT against model, then advance model by what the clock edge will do.
  task automatic step(output bit xfer);
    int dst;
    bit expStop;
    #1;
    chk("wrReady", DW'(smiWrReqReady), DW'(wrQ.size() != 0));
    if (wrQ.size() != 0) begin
      chk("wrEofc", DW'(smiWrReqEofc), DW'(wrQ[0][DW+7:DW]));
      chk("wrData", smiWrReqData, wrQ[0][DW-1:0]);
    end
    chk("rdReady", DW'(smiRdReqReady), DW'(rdQ.size() != 0));
    if (rdQ.size() != 0) begin
      chk("rdEofc", DW'(smiRdReqEofc), DW'(rdQ[0][DW+7:DW]));
      chk("rdData", smiRdReqData, rdQ[0][DW-1:0]);
    end
    chk("dropCount", DW'(dropCount), DW'(expDrop));
    dst = (mFrame == 0) ? decode(smiReqData[7:0]) : mFrame;
    if (mFrame == 0 && !smiReqReady) expStop = 1'b1;
    else if (dst == 3) expStop = 1'b0;
    else expStop = (((dst == 1) ? wrQ.size() : rdQ.size()) == 2);
    chk("reqStop", DW'(smiReqStop), DW'(expStop));
    if (smiReqReady && smiReqStop) sawStop = 1'b1;
    xfer = smiReqReady && !expStop;
    if (wrQ.size() != 0 && !smiWrReqStop) void'(wrQ.pop_front());
    if (rdQ.size() != 0 && !smiRdReqStop) void'(rdQ.pop_front());
    if (xfer) begin
      if (dst == 1) wrQ.push_back({smiReqEofc, smiReqData});
      if (dst == 2) rdQ.push_back({smiReqEofc, smiReqData});
      if (dst == 3 && mFrame == 0 && expDrop != 8'hFF) expDrop = expDrop + 8'd1;
      mFrame = (smiReqEofc != 8'd0) ? 0 : dst;
    end
    @(posedge clk);
    @(negedge clk);
    applyStops();
  endtask

  task automatic idle(input int n);
    bit x;
    smiReqReady = 1'b0;
    for (int i = 0; i < n; i++) step(x);
  endtask

  task automatic sendFrame(input logic [7:0] typ, input int n, input int gapPct,
                           input logic [7:0] lastEofc, output int cyc);
    logic [DW-1:0] d;
    logic [7:0]    e;
    bit            x;
    int            tries;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) begin
        d[7:0] = typ;
        headData = d;
      end
      e = (i == n - 1) ? ((lastEofc != 8'd0) ? lastEofc : 8'($urandom_range(1, 16))) : 8'd0;
      tries = 0;
      x = 1'b0;
      while (!x) begin
        if (tries > 300) begin
          checks++;
          errors++;
          $display("FAIL stallTimeout actual=no-accept expected=accept within 300 cycles");
          smiReqReady = 1'b0;
          return;
        end
        if ($urandom_range(0, 99) < gapPct) smiReqReady = 1'b0;
        else begin
          smiReqReady = 1'b1;
          smiReqData  = d;
          smiReqEofc  = e;
        end
        step(x);
        cyc++;
        tries++;
      end
    end
    smiReqReady = 1'b0;
  endtask

  task automatic doReset();
    nreset = 1'b0;
    #1;
    chk("rstStop", DW'(smiReqStop), DW'(1));
    chk("rstWrReady", DW'(smiWrReqReady), DW'(0));
    chk("rstRdReady", DW'(smiRdReqReady), DW'(0));
    chk("rstDrop", DW'(dropCount), DW'(0));
    smiReqReady = 1'b0;
    wrQ.delete();
    rdQ.delete();
    mFrame = 0;
    expDrop = 8'd0;
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    int cyc;
    int total;
    bit x;
    nreset = 1'b1;
    smiReqReady = 1'b0;
    smiReqEofc = 8'd0;
    smiReqData = '0;
    smiWrReqStop = 1'b0;
    smiRdReqStop = 1'b0;
    #2;
    doReset();
    setHold(0, 0);

    // Single-flit write frame, visible next cycle.
    sendFrame(8'h02, 1, 0, 8'd4, cyc);
    chk("t1WrReady", DW'(smiWrReqReady), DW'(1));
    chk("t1WrEofc", DW'(smiWrReqEofc), DW'(8'd4));
    chk("t1WrData", smiWrReqData, headData);
    chk("t1RdReady", DW'(smiRdReqReady), DW'(0));
    idle(2);

    // Read frame against a 4-cycle output stall.
    sawStop = 1'b0;
    setHold(0, 4);
    sendFrame(8'h01, 3, 0, 8'd16, cyc);
    chk("t2Cycles", DW'(cyc), DW'(6));
    chk("t2SawStop", DW'(sawStop), DW'(1));
    idle(4);

    // Unknown-type frames are discarded and counted, saturating.
    sawStop = 1'b0;
    sendFrame(8'h7A, 2, 0, 8'd0, cyc);
    idle(1);
    chk("t3Drop1", DW'(dropCount), DW'(8'd1));
    for (int i = 0; i < 300; i++) sendFrame(8'h7A, 2, 0, 8'd0, cyc);
    idle(1);
    chk("t3Drop255", DW'(dropCount), DW'(8'hFF));
    chk("t3NoStop", DW'(sawStop), DW'(0));

    // Back-to-back W2, R1, W1 with no stalls.
    total = 0;
    sendFrame(8'h02, 2, 0, 8'd0, cyc); total += cyc;
    sendFrame(8'h01, 1, 0, 8'd0, cyc); total += cyc;
    sendFrame(8'h02, 1, 0, 8'd0, cyc); total += cyc;
    chk("t4Cycles", DW'(total), DW'(4));
    idle(3);

    // Reset in the middle of a write frame.
    smiReqReady = 1'b1;
    smiReqData = {$urandom, $urandom, $urandom, $urandom};
    smiReqData[7:0] = 8'h02;
    smiReqEofc = 8'd0;
    step(x);
    chk("t5WrBefore", DW'(smiWrReqReady), DW'(1));
    smiReqData = {$urandom, $urandom, $urandom, $urandom};
    doReset();
    sendFrame(8'h01, 1, 0, 8'd8, cyc);
    chk("t5RdReady", DW'(smiRdReqReady), DW'(1));
    chk("t5RdEofc", DW'(smiRdReqEofc), DW'(8'd8));
    chk("t5WrIdle", DW'(smiWrReqReady), DW'(0));
    idle(2);

    // Write FIFO full: read head passes, write head waits for the stop to fall.
    setHold(20, 0);
    sendFrame(8'h02, 1, 0, 8'd0, cyc);
    sendFrame(8'h02, 1, 0, 8'd0, cyc);
    sendFrame(8'h01, 1, 0, 8'd0, cyc);
    chk("t6RdPass", DW'(cyc), DW'(1));
    sendFrame(8'h02, 1, 0, 8'd0, cyc);
    chk("t6WrWait", DW'(cyc), DW'(19));
    idle(4);

    // Randomized traffic, gaps and backpressure.
    doReset();
    randStops = 1'b1;
    applyStops();
    for (int f = 0; f < 300; f++) begin
      logic [7:0] t;
      case ($urandom_range(0, 3))
        0:       t = 8'h02;
        1:       t = 8'h01;
        2:       t = 8'h7A;
        default: t = 8'($urandom);
      endcase
      sendFrame(t, $urandom_range(1, 4), 25, 8'd0, cyc);
    end
    randStops = 1'b0;
    setHold(0, 0);
    idle(6);
    chk("drainWr", DW'(wrQ.size()), DW'(0));
    chk("drainRd", DW'(rdQ.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
